text_term_buf: RTL and testbench
================================

TEXT_TERM_BUF -- requirements
Module: text_term_buf

Interface
REQ-001 Parameter COLS, default 70, characters per screen row (2..256).
REQ-002 Parameter ROWS, default 30, screen rows (2..256).
REQ-003 Parameter WRAP, default 1: 1 = auto-newline after last column; 0 = cursor sticks at last column.
REQ-004 Derived CW = clog2(COLS), RW = clog2(ROWS); not user-overridable.
REQ-005 clk  input  1  sole clock, rising edge.
REQ-006 clrn  input  1  reset, synchronous, active-low.
REQ-007 key_valid  input  1  one-cycle pulse: key_ascii holds a new pressed key.
REQ-008 key_ascii  input  8  ASCII code of the key.
REQ-009 busy  output  1  high while clearing or scrolling; key events dropped.
REQ-010 rd_col  input  CW  display read column.
REQ-011 rd_row  input  RW  display read row, logical (0 = top of visible screen).
REQ-012 rd_char  output  8  character at (rd_row, rd_col).
REQ-013 cur_col  output  CW  cursor column.
REQ-014 cur_row  output  RW  cursor logical row.
REQ-015 top_row  output  RW  physical RAM row currently shown as logical row 0.

Function
REQ-016 Storage: ROWS*COLS x 8 RAM; address = phys_row*COLS + col; phys_row = (top_row + logical_row) mod ROWS.
REQ-017 FSM states IDLE, CLEAR, SCROLL_CLR; only IDLE accepts key_valid.
REQ-018 CLEAR: write 0x20 to every cell, one per cycle (ROWS*COLS cycles), busy=1, then IDLE.
REQ-019 Printable 0x20..0x7E in IDLE: write at cursor same cycle; cur_col+1 next cycle.
REQ-020 Printable at cur_col=COLS-1: WRAP=1 -> perform newline (REQ-022) after write; WRAP=0 -> cursor unchanged, next printable overwrites the same cell.
REQ-021 0x0D or 0x0A: newline.
REQ-022 Newline: cur_col=0; cur_row<ROWS-1 -> cur_row+1; else top_row=(top_row+1) mod ROWS, cur_row unchanged, enter SCROLL_CLR.
REQ-023 SCROLL_CLR: write 0x20 to all COLS cells of new bottom physical row (old top_row), busy=1 for exactly COLS cycles, then IDLE.
REQ-024 0x08 (backspace): cur_col>0 -> cur_col-1 and write 0x20 there; cur_col=0 and cur_row>0 -> cur_row-1, cur_col=COLS-1, write 0x20 there; at (0,0) no-op; never scrolls back.
REQ-025 All other codes ignored, no state change.
REQ-026 key_valid while busy: dropped, no queuing.
REQ-027 Read port: rd_char registered, 1-cycle latency, uses top_row of the request cycle; rd_col>=COLS or rd_row>=ROWS returns 0x20.
REQ-028 Read/write same cell same cycle: rd_char returns the old value.
REQ-029 busy asserted the cycle after the triggering event/reset and deasserted the cycle after the final clear write.

Reset
REQ-030 clrn=0 at a rising clk edge: cur_col=0, cur_row=0, top_row=0, rd_char=0x20, state=CLEAR, busy=1 next cycle.
REQ-031 Reset during CLEAR or SCROLL_CLR aborts it and restarts full CLEAR from address 0.
REQ-032 RAM contents undefined until first CLEAR completes; reads during CLEAR may return stale data.

Structure
REQ-033 Package text_term_pkg holds ASCII constants (ASC_BS=0x08, ASC_LF=0x0A, ASC_CR=0x0D, ASC_SP=0x20, ASC_TILDE=0x7E) and the state enum.
REQ-034 One sub-module text_term_ram: simple dual-port RAM, one sync write port, one registered read port, parameterised depth/width.
REQ-035 Modulo arithmetic by compare-and-subtract, no dividers; RTL 120-400 lines.

Verification (bench COLS=8, ROWS=4)
REQ-036 Reset held 3 cycles then released -> busy high 32 cycles; all 32 cells read 0x20; cursor (0,0).
REQ-037 Keys 'A','B','C' -> cells (0,0..2)=0x41,0x42,0x43; cur_col=3; rd_char valid 1 cycle after address.
REQ-038 WRAP=1, 9 x 'x' -> row 0 all 0x78, (1,0)=0x78, cursor (1,1); WRAP=0 same -> (0,7)=0x78, cursor (0,7), row 1 blank.
REQ-039 Cursor (3,2), CR -> top_row=1, busy 8 cycles, logical row 3 reads all 0x20, cursor (3,0); key during busy dropped.
REQ-040 Cursor (1,0), BS -> cursor (0,7), (0,7)=0x20; at (0,0) BS -> no change.
REQ-041 clrn low mid-SCROLL_CLR -> full 32-cycle CLEAR, top_row=0, cursor (0,0).

Source files
------------

// File: rtl/text_term_pkg.sv
// Shared constants, FSM state type and row-wrap helper for the text terminal buffer.
package text_term_pkg;

    localparam logic [7:0] ASC_BS    = 8'h08;
    localparam logic [7:0] ASC_LF    = 8'h0A;
    localparam logic [7:0] ASC_CR    = 8'h0D;
    localparam logic [7:0] ASC_SP    = 8'h20;
    localparam logic [7:0] ASC_TILDE = 8'h7E;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        CLEAR      = 2'd1,
        SCROLL_CLR = 2'd2
    } term_state_e;

    // (a + b) mod m for a, b < m <= 256, using a single compare-and-subtract
    function automatic logic [8:0] wrap_add(input logic [8:0] a, input logic [8:0] b,
                                            input logic [8:0] m);
        logic [9:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        if (sum >= {1'b0, m}) begin
            sum = sum - {1'b0, m};
        end else begin
            sum = sum;
        end
        return sum[8:0];
    endfunction

endpackage

// File: rtl/text_term_ram.sv
// Simple dual-port character RAM: one synchronous write port, one registered read port.
module text_term_ram #(
    parameter int  DEPTH = 2100,
    parameter int  WIDTH = 8,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem_r [DEPTH];

    // Write and read in one block so a same-address read returns the old contents
    always_ff @(posedge clk) begin
        if (we) begin
            mem_r[waddr] <= wdata;
        end
        rdata <= mem_r[raddr];
    end

endmodule

// File: rtl/text_term_buf.sv
// Character-cell terminal buffer: key decoding, cursor tracking, hardware scrolling
// by rotating the top physical row, and a registered display read port.
module text_term_buf
    import text_term_pkg::*;
#(
    parameter int  COLS = 70,
    parameter int  ROWS = 30,
    parameter int  WRAP = 1,
    localparam int CW   = $clog2(COLS),
    localparam int RW   = $clog2(ROWS)
) (
    input  logic          clk,
    input  logic          clrn,
    input  logic          key_valid,
    input  logic [7:0]    key_ascii,
    output logic          busy,
    input  logic [CW-1:0] rd_col,
    input  logic [RW-1:0] rd_row,
    output logic [7:0]    rd_char,
    output logic [CW-1:0] cur_col,
    output logic [RW-1:0] cur_row,
    output logic [RW-1:0] top_row
);

    localparam int            CELLS    = ROWS * COLS;
    localparam int            AW       = $clog2(CELLS);
    localparam logic [CW-1:0] LAST_COL = CW'(COLS - 1);
    localparam logic [RW-1:0] LAST_ROW = RW'(ROWS - 1);
    localparam logic [AW-1:0] LAST_CELL = AW'(CELLS - 1);
    localparam logic [AW-1:0] LAST_SCR  = AW'(COLS - 1);
    localparam bit            WRAP_EN  = WRAP[0];

    term_state_e   state_r, state_nxt_s;
    logic [CW-1:0] cur_col_r;
    logic [RW-1:0] cur_row_r, top_row_r;
    logic [AW-1:0] cnt_r, base_r;
    logic          rd_blank_r;

    logic          accept_s, is_print_s, is_nl_s, is_bs_s, do_nl_s, scroll_s, key_we_s;
    logic [RW-1:0] key_row_s, key_phys_s;
    logic [CW-1:0] key_col_s;
    logic [7:0]    key_data_s;
    logic [AW-1:0] key_addr_s;

    logic          rd_oob_s;
    logic [RW-1:0] rd_phys_s;
    logic [AW-1:0] rd_addr_s;

    logic          ram_we_s;
    logic [AW-1:0] ram_waddr_s;
    logic [7:0]    ram_wdata_s, ram_rdata_s;

    // Key decode: target cell, write data and newline request for an accepted key
    always_comb begin
        accept_s   = key_valid && (state_r == IDLE);
        is_print_s = (key_ascii >= ASC_SP) && (key_ascii <= ASC_TILDE);
        is_nl_s    = (key_ascii == ASC_CR) || (key_ascii == ASC_LF);
        is_bs_s    = (key_ascii == ASC_BS);
        key_row_s  = cur_row_r;
        key_col_s  = cur_col_r;
        key_data_s = key_ascii;
        key_we_s   = 1'b0;
        do_nl_s    = 1'b0;
        if (!accept_s) begin
            key_we_s = 1'b0;
        end else if (is_print_s) begin
            key_we_s = 1'b1;
            do_nl_s  = WRAP_EN && (cur_col_r == LAST_COL);
        end else if (is_nl_s) begin
            do_nl_s = 1'b1;
        end else if (is_bs_s) begin
            key_data_s = ASC_SP;
            if (cur_col_r != {CW{1'b0}}) begin
                key_we_s  = 1'b1;
                key_col_s = cur_col_r - CW'(1);
            end else if (cur_row_r != {RW{1'b0}}) begin
                key_we_s  = 1'b1;
                key_row_s = cur_row_r - RW'(1);
                key_col_s = LAST_COL;
            end else begin
                key_we_s = 1'b0;
            end
        end else begin
            key_we_s = 1'b0;
        end
        scroll_s   = do_nl_s && (cur_row_r == LAST_ROW);
        key_phys_s = RW'(wrap_add(9'(top_row_r), 9'(key_row_s), 9'(ROWS)));
        key_addr_s = AW'(int'(key_phys_s) * COLS + int'(key_col_s));
    end

    // Read address: logical row mapped through top_row; out-of-range cells read as blank
    always_comb begin
        rd_oob_s  = (int'(rd_col) >= COLS) || (int'(rd_row) >= ROWS);
        rd_phys_s = RW'(wrap_add(9'(top_row_r), 9'(rd_row), 9'(ROWS)));
        if (rd_oob_s) begin
            rd_addr_s = {AW{1'b0}};
        end else begin
            rd_addr_s = AW'(int'(rd_phys_s) * COLS + int'(rd_col));
        end
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (!clrn) begin
            state_r <= CLEAR;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // FSM next-state logic
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (scroll_s) begin
                    state_nxt_s = SCROLL_CLR;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            CLEAR: begin
                if (cnt_r == LAST_CELL) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = CLEAR;
                end
            end
            SCROLL_CLR: begin
                if (cnt_r == LAST_SCR) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = SCROLL_CLR;
                end
            end
            default: state_nxt_s = CLEAR;
        endcase
    end

    // FSM outputs: RAM write port source and busy flag
    always_comb begin
        ram_we_s    = 1'b0;
        ram_waddr_s = key_addr_s;
        ram_wdata_s = ASC_SP;
        busy        = (state_r != IDLE);
        case (state_r)
            IDLE: begin
                ram_we_s    = key_we_s;
                ram_waddr_s = key_addr_s;
                ram_wdata_s = key_data_s;
            end
            CLEAR: begin
                ram_we_s    = 1'b1;
                ram_waddr_s = cnt_r;
            end
            SCROLL_CLR: begin
                ram_we_s    = 1'b1;
                ram_waddr_s = base_r + cnt_r;
            end
            default: ram_we_s = 1'b0;
        endcase
    end

    // Cursor, scroll origin, clear counter and read-blank flag
    always_ff @(posedge clk) begin
        if (!clrn) begin
            cur_col_r  <= {CW{1'b0}};
            cur_row_r  <= {RW{1'b0}};
            top_row_r  <= {RW{1'b0}};
            cnt_r      <= {AW{1'b0}};
            base_r     <= {AW{1'b0}};
            rd_blank_r <= 1'b1;
        end else begin
            rd_blank_r <= rd_oob_s;
            if (state_r == IDLE) begin
                cnt_r <= {AW{1'b0}};
            end else begin
                cnt_r <= cnt_r + AW'(1);
            end
            if (do_nl_s) begin
                cur_col_r <= {CW{1'b0}};
                if (cur_row_r != LAST_ROW) begin
                    cur_row_r <= cur_row_r + RW'(1);
                end else begin
                    // Old top row becomes the new bottom row and is blanked by SCROLL_CLR
                    top_row_r <= RW'(wrap_add(9'(top_row_r), 9'd1, 9'(ROWS)));
                    base_r    <= AW'(int'(top_row_r) * COLS);
                end
            end else if (accept_s && is_print_s) begin
                if (cur_col_r != LAST_COL) begin
                    cur_col_r <= cur_col_r + CW'(1);
                end
            end else if (accept_s && is_bs_s) begin
                cur_col_r <= key_col_s;
                cur_row_r <= key_row_s;
            end
        end
    end

    text_term_ram #(
        .DEPTH (CELLS),
        .WIDTH (8)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we_s),
        .waddr (ram_waddr_s),
        .wdata (ram_wdata_s),
        .raddr (rd_addr_s),
        .rdata (ram_rdata_s)
    );

    assign rd_char = rd_blank_r ? ASC_SP : ram_rdata_s;
    assign cur_col = cur_col_r;
    assign cur_row = cur_row_r;
    assign top_row = top_row_r;

endmodule

// File: tb/tb_text_term_buf.sv
// Bench for text_term_buf (8x4): a WRAP=1 and a WRAP=0 instance share stimulus and are
// compared every cycle against a logical-screen reference model.
module tb_text_term_buf;

    localparam int COLS  = 8;
    localparam int ROWS  = 4;
    localparam int CELLS = COLS * ROWS;

    logic       clk = 1'b0;
    logic       clrn;
    logic       key_valid;
    logic [7:0] key_ascii;
    logic [2:0] rd_col;
    logic [1:0] rd_row;

    logic       busy_s    [2];
    logic [7:0] rd_char_s [2];
    logic [2:0] cur_col_s [2];
    logic [1:0] cur_row_s [2];
    logic [1:0] top_row_s [2];

    always #5 clk = ~clk;

    text_term_buf #(.COLS(COLS), .ROWS(ROWS), .WRAP(1)) dut_wrap (
        .clk(clk), .clrn(clrn), .key_valid(key_valid), .key_ascii(key_ascii),
        .busy(busy_s[0]), .rd_col(rd_col), .rd_row(rd_row), .rd_char(rd_char_s[0]),
        .cur_col(cur_col_s[0]), .cur_row(cur_row_s[0]), .top_row(top_row_s[0])
    );

    text_term_buf #(.COLS(COLS), .ROWS(ROWS), .WRAP(0)) dut_stick (
        .clk(clk), .clrn(clrn), .key_valid(key_valid), .key_ascii(key_ascii),
        .busy(busy_s[1]), .rd_col(rd_col), .rd_row(rd_row), .rd_char(rd_char_s[1]),
        .cur_col(cur_col_s[1]), .cur_row(cur_row_s[1]), .top_row(top_row_s[1])
    );

    int nvec = 0;
    int nmis = 0;

    // Reference model: screen held in logical row order; scrolling shifts rows up
    logic [7:0] scr [2][ROWS][COLS];
    int m_col [2];
    int m_row [2];
    int m_top [2];
    int m_busy [2];

    typedef struct {
        int kv; int key; int rr; int rc;
        int ecol; int erow; int etop; int ebusy; int erd;
    } vec_t;
    vec_t tbl [14];

    task automatic check(input string name, input int inst, input logic [31:0] act,
                         input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nmis++;
            $display("FAIL %s[%0d] at %0t: got %0h expected %0h", name, inst, $time, act, exp);
        end
    endtask

    task automatic m_newline(input int i);
        m_col[i] = 0;
        if (m_row[i] < ROWS - 1) begin
            m_row[i]++;
        end else begin
            for (int r = 0; r < ROWS - 1; r++)
                for (int c = 0; c < COLS; c++) scr[i][r][c] = scr[i][r+1][c];
            for (int c = 0; c < COLS; c++) scr[i][ROWS-1][c] = 8'h20;
            m_top[i]  = (m_top[i] + 1) % ROWS;
            m_busy[i] = COLS;
        end
    endtask

    task automatic m_key(input int i, input logic [7:0] k);
        if (k >= 8'h20 && k <= 8'h7E) begin
            scr[i][m_row[i]][m_col[i]] = k;
            if (m_col[i] < COLS - 1) m_col[i]++;
            else if (i == 0) m_newline(i);
        end else if (k == 8'h0D || k == 8'h0A) begin
            m_newline(i);
        end else if (k == 8'h08) begin
            if (m_col[i] > 0) begin
                m_col[i]--;
                scr[i][m_row[i]][m_col[i]] = 8'h20;
            end else if (m_row[i] > 0) begin
                m_row[i]--;
                m_col[i] = COLS - 1;
                scr[i][m_row[i]][m_col[i]] = 8'h20;
            end
        end
    endtask

    task automatic m_edge(input bit rst, input bit kv, input logic [7:0] k);
        for (int i = 0; i < 2; i++) begin
            if (rst) begin
                m_col[i] = 0; m_row[i] = 0; m_top[i] = 0; m_busy[i] = CELLS;
                for (int r = 0; r < ROWS; r++)
                    for (int c = 0; c < COLS; c++) scr[i][r][c] = 8'h20;
            end else if (m_busy[i] > 0) begin
                m_busy[i]--;
            end else if (kv) begin
                m_key(i, k);
            end
        end
    endtask

    // One clock: drive inputs, advance model, compare both instances #1 after the edge
    task automatic tick(input bit rst, input bit kv, input logic [7:0] k, input int rr, input int rc);
        logic [7:0] erd [2];
        bit         ev  [2];
        clrn = ~rst; key_valid = kv; key_ascii = k;
        rd_row = 2'(rr); rd_col = 3'(rc);
        for (int i = 0; i < 2; i++) begin
            ev[i]  = rst || (m_busy[i] == 0);
            erd[i] = rst ? 8'h20 : scr[i][rr][rc];
        end
        @(posedge clk);
        m_edge(rst, kv, k);
        #1;
        for (int i = 0; i < 2; i++) begin
            check("busy", i, 32'(busy_s[i]), (m_busy[i] != 0) ? 1 : 0);
            check("cur_col", i, 32'(cur_col_s[i]), m_col[i]);
            check("cur_row", i, 32'(cur_row_s[i]), m_row[i]);
            check("top_row", i, 32'(top_row_s[i]), m_top[i]);
            if (ev[i]) check("rd_char", i, 32'(rd_char_s[i]), 32'(erd[i]));
        end
        @(negedge clk);
    endtask

    task automatic count_busy(input bit kv, input logic [7:0] k, output int n);
        n = 0;
        while (busy_s[0] === 1'b1 && n < 100) begin
            n++;
            tick(1'b0, kv, k, 0, 0);
        end
    endtask

    task automatic do_reset(input int cycles, output int n);
        for (int j = 0; j < cycles; j++) tick(1'b1, 1'b0, 8'h00, 0, 0);
        count_busy(1'b0, 8'h00, n);
    endtask

    initial begin
        int n;
        clrn = 1'b0; key_valid = 1'b0; key_ascii = 8'h00; rd_row = 2'd0; rd_col = 3'd0;
        tbl[0]  = '{1, 'h41, 0, 0, 1, 0, 0, 0, 'h20};
        tbl[1]  = '{1, 'h42, 0, 0, 2, 0, 0, 0, 'h41};
        tbl[2]  = '{1, 'h43, 0, 1, 3, 0, 0, 0, 'h42};
        tbl[3]  = '{0, 'h00, 0, 2, 3, 0, 0, 0, 'h43};
        tbl[4]  = '{1, 'h07, 0, 3, 3, 0, 0, 0, 'h20};
        tbl[5]  = '{1, 'h08, 0, 2, 2, 0, 0, 0, 'h43};
        tbl[6]  = '{0, 'h00, 0, 2, 2, 0, 0, 0, 'h20};
        tbl[7]  = '{1, 'h0A, 0, 1, 0, 1, 0, 0, 'h42};
        tbl[8]  = '{1, 'h08, 1, 0, 7, 0, 0, 0, 'h20};
        tbl[9]  = '{1, 'h7A, 0, 7, 0, 1, 0, 0, 'h20};
        tbl[10] = '{0, 'h00, 0, 7, 0, 1, 0, 0, 'h7A};
        tbl[11] = '{1, 'h08, 0, 7, 7, 0, 0, 0, 'h7A};
        tbl[12] = '{0, 'h00, 0, 7, 7, 0, 0, 0, 'h20};
        tbl[13] = '{1, 'hFF, 0, 0, 7, 0, 0, 0, 'h41};
        @(negedge clk);

        // Reset held 3 cycles, then a full clear of every cell
        do_reset(3, n);
        check("clear_busy_len", 0, n, CELLS);
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++) begin
                tick(1'b0, 1'b0, 8'h00, r, c);
                check("clear_cell", 0, 32'(rd_char_s[0]), 32'h20);
            end
        check("reset_col", 0, 32'(cur_col_s[0]), 0);
        check("reset_row", 0, 32'(cur_row_s[0]), 0);

        // Directed table on the wrapping instance
        for (int j = 0; j < 14; j++) begin
            tick(1'b0, tbl[j].kv[0], 8'(tbl[j].key), tbl[j].rr, tbl[j].rc);
            check("tbl_col", j, 32'(cur_col_s[0]), tbl[j].ecol);
            check("tbl_row", j, 32'(cur_row_s[0]), tbl[j].erow);
            check("tbl_top", j, 32'(top_row_s[0]), tbl[j].etop);
            check("tbl_busy", j, 32'(busy_s[0]), tbl[j].ebusy);
            check("tbl_rd", j, 32'(rd_char_s[0]), tbl[j].erd);
        end

        // Nine printables: wrap vs stick at last column
        do_reset(1, n);
        for (int j = 0; j < 9; j++) tick(1'b0, 1'b1, 8'h78, 0, 0);
        check("wrap_col", 0, 32'(cur_col_s[0]), 1);
        check("wrap_row", 0, 32'(cur_row_s[0]), 1);
        check("stick_col", 1, 32'(cur_col_s[1]), 7);
        check("stick_row", 1, 32'(cur_row_s[1]), 0);
        for (int c = 0; c < COLS; c++) begin
            tick(1'b0, 1'b0, 8'h00, 0, c);
            check("row0", 0, 32'(rd_char_s[0]), 32'h78);
            check("row0", 1, 32'(rd_char_s[1]), 32'h78);
        end
        for (int c = 0; c < COLS; c++) begin
            tick(1'b0, 1'b0, 8'h00, 1, c);
            check("row1", 0, 32'(rd_char_s[0]), (c == 0) ? 32'h78 : 32'h20);
            check("row1", 1, 32'(rd_char_s[1]), 32'h20);
        end

        // Scroll from (3,2); keys during SCROLL_CLR are dropped
        do_reset(1, n);
        tick(1'b0, 1'b1, 8'h0A, 0, 0);
        tick(1'b0, 1'b1, 8'h0A, 0, 0);
        tick(1'b0, 1'b1, 8'h0A, 0, 0);
        tick(1'b0, 1'b1, 8'h61, 0, 0);
        tick(1'b0, 1'b1, 8'h62, 0, 0);
        check("pre_scroll_col", 0, 32'(cur_col_s[0]), 2);
        tick(1'b0, 1'b1, 8'h0D, 0, 0);
        check("scroll_top", 0, 32'(top_row_s[0]), 1);
        count_busy(1'b1, 8'h51, n);
        check("scroll_busy_len", 0, n, COLS);
        check("scroll_col", 0, 32'(cur_col_s[0]), 0);
        check("scroll_row", 0, 32'(cur_row_s[0]), 3);
        for (int c = 0; c < COLS; c++) begin
            tick(1'b0, 1'b0, 8'h00, 3, c);
            check("bottom_blank", 0, 32'(rd_char_s[0]), 32'h20);
        end
        tick(1'b0, 1'b0, 8'h00, 2, 1);
        check("shifted_cell", 0, 32'(rd_char_s[0]), 32'h62);

        // Reset in the middle of SCROLL_CLR restarts a full clear
        tick(1'b0, 1'b1, 8'h0D, 0, 0);
        tick(1'b0, 1'b0, 8'h00, 0, 0);
        tick(1'b1, 1'b0, 8'h00, 0, 0);
        count_busy(1'b0, 8'h00, n);
        check("abort_busy_len", 0, n, CELLS);
        check("abort_top", 0, 32'(top_row_s[0]), 0);
        check("abort_col", 0, 32'(cur_col_s[0]), 0);
        check("abort_row", 0, 32'(cur_row_s[0]), 0);

        // Backspace at home is a no-op
        tick(1'b0, 1'b1, 8'h08, 0, 0);
        check("bs_home_col", 0, 32'(cur_col_s[0]), 0);
        check("bs_home_row", 0, 32'(cur_row_s[0]), 0);

        // Random key and read traffic against the model
        for (int j = 0; j < 600; j++) begin
            int          sel;
            bit          kv;
            logic [7:0]  k;
            sel = int'($urandom_range(0, 99));
            kv  = 1'b1;
            if (sel < 40)      k = 8'($urandom_range(32, 126));
            else if (sel < 50) k = (sel < 45) ? 8'h0D : 8'h0A;
            else if (sel < 65) k = 8'h08;
            else if (sel < 72) k = 8'($urandom_range(127, 255));
            else begin kv = 1'b0; k = 8'($urandom_range(0, 255)); end
            tick(1'b0, kv, k, int'($urandom_range(0, ROWS - 1)), int'($urandom_range(0, COLS - 1)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule
